arb_xfer_ctrl: RTL and testbench
================================

# arb_xfer_ctrl

Burst transfer controller directly downstream of the 3-requester round-robin arbiter. Samples the arbiter's encoded grant, locks ownership of a shared output channel to the granted requester, and moves a fixed-length burst of BEATS data words over a valid/ready handshake. Ownership is released only after the burst completes. The controller emits per-requester beat acknowledges and a burst-done pulse.

## Interface
- DW, 8: data width per requester and output channel
- BEATS, 4: beats per burst, must be ≥1; CW = max(1, $clog2(BEATS))
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset; assertion clears all state immediately, deassertion synchronous to clk
- grant  in  3  arbiter grant, encoded: 000 none, 001 requester0, 010 requester1, 011 requester2, 100–111 invalid
- wdata0, wdata1, wdata2  in  DW each  current beat data from each requester
- out_ready  in  1  sink accepts beat
- out_valid  out  1  beat present on out_data
- out_data  out  DW  wdata of current owner
- out_src  out  2  owner index 0/1/2; 0 when not XFER
- out_beat  out  CW  index of current beat, 0..BEATS-1
- req_ack  out  3  one-hot; bit i high in the cycle requester i's beat is accepted
- burst_done  out  3  one-hot; one-cycle pulse to the owner after its final beat
- busy  out  1  high in XFER and DONE

## Operation
- States: IDLE, XFER, DONE. Registers: state, owner[1:0], cnt[CW-1:0], burst_done[2:0].
- IDLE: grant 001/010/011 sampled → owner = 0/1/2, cnt = 0, next XFER. grant 000 or 100–111 → stay IDLE (invalid codes silently ignored).
- XFER: out_valid = 1; out_data = wdata[owner] (combinational mux on registered owner); out_src = owner; out_beat = cnt.
- Handshake: beat accepted iff out_valid && out_ready. req_ack[owner] = out_valid & out_ready (combinational, same cycle). out_valid never drops in XFER until the final beat is accepted; out_data follows wdata[owner] live, so requesters must hold data stable until their req_ack.
- Accepted beat with cnt < BEATS-1 → cnt+1. Accepted beat with cnt == BEATS-1 → next DONE, burst_done[owner] set (registered).
- DONE: one cycle; burst_done[owner] = 1, out_valid = 0, grant ignored; next IDLE, burst_done cleared.
- grant is ignored in XFER and DONE; changes there have no effect on owner, cnt, or data.
- BEATS = 1: single handshake, then DONE.

## Timing
- Reset values: out_valid 0, out_data 0 (mux gated to 0 outside XFER), out_src 0, out_beat 0, req_ack 000, burst_done 000, busy 0; state IDLE, owner 0, cnt 0.
- Grant-to-valid latency: grant valid at edge N in IDLE → out_valid high after edge N, i.e. in cycle N+1.
- Minimum burst: BEATS cycles in XFER with out_ready held high, then 1 DONE cycle, then 1 IDLE cycle. Earliest next out_valid is 2 cycles after the final handshake.
- Stall: out_ready low holds cnt, out_data source, and out_valid indefinitely.
- Reset mid-burst: immediate return to IDLE; partial burst dropped; no burst_done pulse; req_ack 0 while reset is asserted.
- busy = (state != IDLE).

## Test plan
- Basic burst: BEATS=4, grant=010 for one cycle, out_ready=1, wdata1 = A0,A1,A2,A3 advancing on each req_ack[1] → out_src=1; out_data A0..A3 on 4 consecutive cycles; req_ack=010 each cycle; burst_done=010 for exactly 1 cycle; busy high for 5 cycles.
- Backpressure: grant=001, out_ready toggled 1,0,0,1,1,0,1 → exactly 4 req_ack[0] pulses, one per cycle with ready high; out_beat 0→3 advances only on those cycles; out_data stable during stalls.
- Grant churn: grant=011, then grant cycles 001/010/000 every cycle during the burst → out_src stays 2 throughout; burst_done=100 only.
- Invalid/none grant: grant=100, 111, then 000 in IDLE → out_valid stays 0, busy 0, no ack. Next grant=001 starts a burst normally.
- Reset mid-burst: grant=010, rst low after 2 accepted beats → all outputs 0 during reset, no burst_done. After release, grant=011 gives a full 4-beat burst from requester 2 with out_beat starting at 0.
- Back-to-back: grant held at 001 continuously with out_ready=1 → bursts of 4 separated by exactly 2 non-valid cycles (DONE, IDLE); each burst ends with a burst_done=001 pulse.

Source files
------------

// File: rtl/arb_xfer_ctrl.sv
// Burst transfer controller: locks the output channel to the granted requester
// and moves one fixed-length burst over a valid/ready handshake.
module arb_xfer_ctrl #(
    parameter  int unsigned DW    = 8,
    parameter  int unsigned BEATS = 4,
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    grant,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic [DW-1:0] wdata2,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [1:0]    out_src,
    output logic [CW-1:0] out_beat,
    output logic [2:0]    req_ack,
    output logic [2:0]    burst_done,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [1:0]    r_owner;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_burst_done;

    logic          w_xfer;
    logic          w_accept;
    logic          w_last;
    logic [DW-1:0] w_mux;

    assign w_xfer   = (r_state == S_XFER);
    assign w_accept = w_xfer & out_ready;
    assign w_last   = (r_cnt == CW'(BEATS - 1));

    // Live data path from the current owner; requesters hold data until acked.
    always_comb begin
        w_mux = '0;
        case (r_owner)
            2'd0:    w_mux = wdata0;
            2'd1:    w_mux = wdata1;
            2'd2:    w_mux = wdata2;
            default: w_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_owner      <= 2'd0;
            r_cnt        <= '0;
            r_burst_done <= 3'b000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_burst_done <= 3'b000;
                    // Encoded grants 1..3 map to owners 0..2; other codes ignored.
                    if (grant == 3'd1 || grant == 3'd2 || grant == 3'd3) begin
                        r_owner <= 2'(grant - 3'd1);
                        r_cnt   <= '0;
                        r_state <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_cnt        <= '0;
                            r_burst_done <= 3'(3'b001 << r_owner);
                            r_state      <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_burst_done <= 3'b000;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_burst_done <= 3'b000;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign out_valid  = w_xfer;
    assign out_data   = w_xfer ? w_mux : '0;
    assign out_src    = w_xfer ? r_owner : 2'd0;
    assign out_beat   = w_xfer ? r_cnt : '0;
    assign req_ack    = w_accept ? 3'(3'b001 << r_owner) : 3'b000;
    assign burst_done = r_burst_done;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_arb_xfer_ctrl.sv
// Directed bench for arb_xfer_ctrl (DW=8, BEATS=4) with immediate-assertion checks.
module tb_arb_xfer_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] grant;
    logic [7:0] wdata0, wdata1, wdata2;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_src;
    logic [1:0] out_beat;
    logic [2:0] req_ack;
    logic [2:0] burst_done;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int acks   = 0;

    int rdy[7] = '{1, 0, 0, 1, 1, 0, 1};
    int bt[7]  = '{0, 1, 1, 1, 2, 3, 3};
    int gch[4] = '{1, 2, 0, 1};

    arb_xfer_ctrl #(.DW(8), .BEATS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .grant      (grant),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .wdata2     (wdata2),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_beat   (out_beat),
        .req_ack    (req_ack),
        .burst_done (burst_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [2:0] g, input logic r,
                         input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2);
        @(negedge clk);
        grant     = g;
        out_ready = r;
        wdata0    = w0;
        wdata1    = w1;
        wdata2    = w2;
        #1;
    endtask

    task automatic chk(input string tag, input logic ev, input logic [7:0] ed,
                       input logic [1:0] es, input logic [1:0] eb, input logic [2:0] ea,
                       input logic [2:0] edn, input logic eby);
        checks++;
        assert (out_valid === ev) else begin
            errors++; $error("FAIL %s out_valid obs=%0b exp=%0b", tag, out_valid, ev);
        end
        checks++;
        assert (out_data === ed) else begin
            errors++; $error("FAIL %s out_data obs=%0h exp=%0h", tag, out_data, ed);
        end
        checks++;
        assert (out_src === es) else begin
            errors++; $error("FAIL %s out_src obs=%0d exp=%0d", tag, out_src, es);
        end
        checks++;
        assert (out_beat === eb) else begin
            errors++; $error("FAIL %s out_beat obs=%0d exp=%0d", tag, out_beat, eb);
        end
        checks++;
        assert (req_ack === ea) else begin
            errors++; $error("FAIL %s req_ack obs=%03b exp=%03b", tag, req_ack, ea);
        end
        checks++;
        assert (burst_done === edn) else begin
            errors++; $error("FAIL %s burst_done obs=%03b exp=%03b", tag, burst_done, edn);
        end
        checks++;
        assert (busy === eby) else begin
            errors++; $error("FAIL %s busy obs=%0b exp=%0b", tag, busy, eby);
        end
    endtask

    initial begin
        rst = 1'b0; grant = 3'd0; out_ready = 1'b0;
        wdata0 = 8'h00; wdata1 = 8'h00; wdata2 = 8'h00;
        #2;
        chk("reset", 0, 8'h00, 0, 0, 3'b000, 3'b000, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_reset", 0, 8'h00, 0, 0, 3'b000, 3'b000, 0);

        // Basic burst from requester 1
        drive(3'd2, 1'b1, 8'h00, 8'hA0, 8'h00);
        chk("basic_idle", 0, 8'h00, 0, 0, 3'b000, 3'b000, 0);
        for (int k = 0; k < 4; k++) begin
            drive(3'd0, 1'b1, 8'h00, 8'(8'hA0 + k), 8'h00);
            chk("basic_xfer", 1, 8'(8'hA0 + k), 2'd1, 2'(k), 3'b010, 3'b000, 1);
        end
        drive(3'd0, 1'b1, 8'h00, 8'hEE, 8'h00);
        chk("basic_done", 0, 8'h00, 0, 0, 3'b000, 3'b010, 1);
        drive(3'd0, 1'b1, 8'h00, 8'hEE, 8'h00);
        chk("basic_idle2", 0, 8'h00, 0, 0, 3'b000, 3'b000, 0);

        // Backpressure on requester 0
        drive(3'd1, 1'b0, 8'h50, 8'h00, 8'h00);
        chk("bp_idle", 0, 8'h00, 0, 0, 3'b000, 3'b000, 0);
        for (int i = 0; i < 7; i++) begin
            drive(3'd0, 1'(rdy[i]), 8'(8'h50 + bt[i]), 8'h00, 8'h00);
            chk("bp_xfer", 1, 8'(8'h50 + bt[i]), 2'd0, 2'(bt[i]),
                (rdy[i] != 0) ? 3'b001 : 3'b000, 3'b000, 1);
            if (req_ack[0]) acks++;
        end
        checks++;
        assert (acks == 4) else begin
            errors++; $error("FAIL bp_ack_count obs=%0d exp=4", acks);
        end
        drive(3'd0, 1'b1, 8'h00, 8'h00, 8'h00);
        chk("bp_done", 0, 8'h00, 0, 0, 3'b000, 3'b001, 1);
        drive(3'd0, 1'b1, 8'h00, 8'h00, 8'h00);
        chk("bp_idle2", 0, 8'h00, 0, 0, 3'b000, 3'b000, 0);

        // Grant churn during a requester-2 burst
        drive(3'd3, 1'b1, 8'h00, 8'h00, 8'hC0);
        chk("churn_idle", 0, 8'h00, 0, 0, 3'b000, 3'b000, 0);
        for (int k = 0; k < 4; k++) begin
            drive(3'(gch[k]), 1'b1, 8'h11, 8'h22, 8'(8'hC0 + k));
            chk("churn_xfer", 1, 8'(8'hC0 + k), 2'd2, 2'(k), 3'b100, 3'b000, 1);
        end
        drive(3'd2, 1'b1, 8'h11, 8'h22, 8'h33);
        chk("churn_done", 0, 8'h00, 0, 0, 3'b000, 3'b100, 1);
        drive(3'd0, 1'b1, 8'h11, 8'h22, 8'h33);
        chk("churn_idle2", 0, 8'h00, 0, 0, 3'b000, 3'b000, 0);

        // Invalid and none grants in IDLE
        drive(3'd4, 1'b1, 8'h10, 8'h00, 8'h00);
        chk("inv_g4", 0, 8'h00, 0, 0, 3'b000, 3'b000, 0);
        drive(3'd7, 1'b1, 8'h10, 8'h00, 8'h00);
        chk("inv_g4_after", 0, 8'h00, 0, 0, 3'b000, 3'b000, 0);
        drive(3'd0, 1'b1, 8'h10, 8'h00, 8'h00);
        chk("inv_g7_after", 0, 8'h00, 0, 0, 3'b000, 3'b000, 0);
        drive(3'd1, 1'b1, 8'h10, 8'h00, 8'h00);
        chk("inv_g0_after", 0, 8'h00, 0, 0, 3'b000, 3'b000, 0);
        for (int k = 0; k < 4; k++) begin
            drive(3'd0, 1'b1, 8'(8'h10 + k), 8'h00, 8'h00);
            chk("inv_burst", 1, 8'(8'h10 + k), 2'd0, 2'(k), 3'b001, 3'b000, 1);
        end
        drive(3'd0, 1'b1, 8'h00, 8'h00, 8'h00);
        chk("inv_done", 0, 8'h00, 0, 0, 3'b000, 3'b001, 1);
        drive(3'd0, 1'b1, 8'h00, 8'h00, 8'h00);
        chk("inv_idle", 0, 8'h00, 0, 0, 3'b000, 3'b000, 0);

        // Reset after two accepted beats
        drive(3'd2, 1'b1, 8'h00, 8'h60, 8'h00);
        chk("rst_idle", 0, 8'h00, 0, 0, 3'b000, 3'b000, 0);
        for (int k = 0; k < 2; k++) begin
            drive(3'd0, 1'b1, 8'h00, 8'(8'h60 + k), 8'h00);
            chk("rst_xfer", 1, 8'(8'h60 + k), 2'd1, 2'(k), 3'b010, 3'b000, 1);
        end
        @(negedge clk);
        rst = 1'b0; wdata1 = 8'h62;
        #1;
        chk("rst_low", 0, 8'h00, 0, 0, 3'b000, 3'b000, 0);
        @(negedge clk);
        #1;
        chk("rst_low2", 0, 8'h00, 0, 0, 3'b000, 3'b000, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_release", 0, 8'h00, 0, 0, 3'b000, 3'b000, 0);
        drive(3'd0, 1'b1, 8'h00, 8'h62, 8'h00);
        chk("rst_no_done", 0, 8'h00, 0, 0, 3'b000, 3'b000, 0);
        drive(3'd3, 1'b1, 8'h00, 8'h62, 8'h70);
        chk("rst_regrant", 0, 8'h00, 0, 0, 3'b000, 3'b000, 0);
        for (int k = 0; k < 4; k++) begin
            drive(3'd0, 1'b1, 8'h00, 8'h62, 8'(8'h70 + k));
            chk("rst_burst2", 1, 8'(8'h70 + k), 2'd2, 2'(k), 3'b100, 3'b000, 1);
        end
        drive(3'd0, 1'b1, 8'h00, 8'h00, 8'h00);
        chk("rst_done2", 0, 8'h00, 0, 0, 3'b000, 3'b100, 1);
        drive(3'd0, 1'b1, 8'h00, 8'h00, 8'h00);
        chk("rst_idle2", 0, 8'h00, 0, 0, 3'b000, 3'b000, 0);

        // Back-to-back bursts with grant held
        drive(3'd1, 1'b1, 8'h80, 8'h00, 8'h00);
        chk("b2b_idle", 0, 8'h00, 0, 0, 3'b000, 3'b000, 0);
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 4; k++) begin
                drive(3'd1, 1'b1, 8'(8'h80 + k), 8'h00, 8'h00);
                chk("b2b_xfer", 1, 8'(8'h80 + k), 2'd0, 2'(k), 3'b001, 3'b000, 1);
            end
            drive(3'd1, 1'b1, 8'h80, 8'h00, 8'h00);
            chk("b2b_done", 0, 8'h00, 0, 0, 3'b000, 3'b001, 1);
            drive(3'd1, 1'b1, 8'h80, 8'h00, 8'h00);
            chk("b2b_gap", 0, 8'h00, 0, 0, 3'b000, 3'b000, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
